cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_handshake_tx.sv | 89 ++++++++
 tb/tb_cdc_handshake_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack clock-domain-crossing handshake with phase timeout
//   clk, rst                    : source clock, asynchronous active-high reset
//   s_valid, s_ready, s_data    : upstream word handshake
//   xfer_req, xfer_data         : registered request and held word toward the destination domain
//   xfer_ack_async              : destination acknowledge, two-flop synchronized before use
//   done, busy                  : one-cycle completion pulse, non-idle status
//   err_timeout, err_clr        : sticky phase-timeout flag and its synchronous clear
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack_async,
    output logic              done,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t        state, state_nxt;
    logic          ack_s1, ack_sync;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept, phase_exit, timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1   <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_s1   <= xfer_ack_async;
            ack_sync <= ack_s1;
        end
    end

    // A high synchronized ack in IDLE is a stale ack from the previous transfer; hold off acceptance.
    assign s_ready = (state == IDLE) && !ack_sync;
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_nxt  = state;
        phase_exit = 1'b0;
        case (state)
            IDLE:    state_nxt = accept ? REQ_HI : IDLE;
            REQ_HI: begin
                phase_exit = ack_sync;
                state_nxt  = ack_sync ? REQ_LO : REQ_HI;
            end
            REQ_LO: begin
                phase_exit = !ack_sync;
                state_nxt  = ack_sync ? REQ_LO : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every phase entry and saturates so the timeout keeps asserting while stuck.
    assign cnt_nxt     = (state_nxt != state || state == IDLE) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign timeout_hit = busy && (cnt == CNT_MAX) && !phase_exit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            xfer_req    <= (state_nxt == REQ_HI);
            done        <= (state == REQ_LO) && (state_nxt == IDLE);
            err_timeout <= timeout_hit || (err_timeout && !err_clr);
            if (accept)
                xfer_data <= s_data;
        end
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: self-checking bench for cdc_handshake_tx with a word scoreboard
module tb_cdc_handshake_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       xfer_req;
    logic [7:0] xfer_data;
    logic       xfer_ack_async = 1'b0;
    logic       done;
    logic       busy;
    logic       err_timeout;
    logic       err_clr = 1'b0;

    int         tests = 0;
    int         fails = 0;
    int         done_seen = 0;
    logic       auto_ack = 1'b0;
    logic       req_q = 1'b0;
    logic [7:0] exp_d;
    logic [7:0] sb[$];

    cdc_handshake_tx #(.DATA_W(8), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack_async(xfer_ack_async),
        .done(done), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Every rising request must carry the next word the bench expects to have been accepted.
    always @(negedge clk) begin
        if (rst) begin
            req_q = 1'b0;
        end else begin
            if (done) done_seen++;
            if (xfer_req && !req_q) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_req: xfer_data=%h but no word was expected", xfer_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (xfer_data !== exp_d) begin
                        fails++;
                        $display("FAIL sb_word: xfer_data=%h expected %h", xfer_data, exp_d);
                    end
                end
            end
            req_q = xfer_req;
        end
    end

    // Destination model: when enabled, ack mirrors req as seen one half-cycle after the edge.
    task automatic step();
        @(negedge clk);
        if (auto_ack) xfer_ack_async = xfer_req;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({xfer_req, done, busy, err_timeout, s_ready, xfer_data} !== {5'b00001, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: req/done/busy/err/rdy/data=%b_%h expected 00001_00",
                     {xfer_req, done, busy, err_timeout, s_ready}, xfer_data);
        end
        rst = 1'b0;
        step();
        tests++;
        if ({busy, s_ready} !== 2'b01) begin
            fails++;
            $display("FAIL reset_release: busy/rdy=%b expected 01", {busy, s_ready});
        end
    endtask

    task automatic test_single();
        logic [2:0] expv;
        auto_ack = 1'b1;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: s_ready=%b expected 1", s_ready);
        end
        s_valid = 1'b1;
        s_data  = 8'hA5;
        sb.push_back(8'hA5);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) begin
                s_valid = 1'b0;
                s_data  = 8'h3C;
            end
            expv = {k <= 3, k == 7, k <= 6};
            tests++;
            if ({xfer_req, done, busy} !== expv) begin
                fails++;
                $display("FAIL single_ctrl k=%0d: req/done/busy=%b expected %b", k, {xfer_req, done, busy}, expv);
            end
            if (k <= 7) begin
                tests++;
                if (xfer_data !== 8'hA5) begin
                    fails++;
                    $display("FAIL single_data k=%0d: xfer_data=%h expected a5", k, xfer_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        auto_ack = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'h01;
        sb.push_back(8'h01);
        for (int k = 1; k <= 16; k++) begin
            step();
            tests++;
            if (done !== (k == 7 || k == 14)) begin
                fails++;
                $display("FAIL b2b_done k=%0d: done=%b expected %b", k, done, (k == 7 || k == 14));
            end
            if (k <= 14) begin
                tests++;
                if (xfer_data !== (k <= 7 ? 8'h01 : 8'h02)) begin
                    fails++;
                    $display("FAIL b2b_data k=%0d: xfer_data=%h expected %h", k, xfer_data, (k <= 7 ? 8'h01 : 8'h02));
                end
            end
            if (k == 7) begin
                tests++;
                if (s_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready: s_ready=%b expected 1 on done cycle", s_ready);
                end
                s_data = 8'h02;
                sb.push_back(8'h02);
            end
            if (k == 14) s_valid = 1'b0;
        end
    endtask

    task automatic test_timeout();
        auto_ack       = 1'b0;
        xfer_ack_async = 1'b0;
        s_valid        = 1'b1;
        s_data         = 8'h5A;
        sb.push_back(8'h5A);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) s_valid = 1'b0;
            if (k <= 12) begin
                tests++;
                if ({xfer_req, err_timeout} !== {1'b1, k >= 9}) begin
                    fails++;
                    $display("FAIL timeout_flag k=%0d: req/err=%b expected 1%b", k, {xfer_req, err_timeout}, k >= 9);
                end
            end
            if (k == 12) begin
                xfer_ack_async = 1'b1;
                auto_ack       = 1'b1;
            end
            if (k >= 13 && k <= 19) begin
                tests++;
                if ({done, err_timeout} !== {k == 18, 1'b1}) begin
                    fails++;
                    $display("FAIL timeout_late_ack k=%0d: done/err=%b expected %b1", k, {done, err_timeout}, k == 18);
                end
            end
            if (k == 19) err_clr = 1'b1;
            if (k == 20) begin
                err_clr = 1'b0;
                tests++;
                if (err_timeout !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_clear: err_timeout=%b expected 0", err_timeout);
                end
            end
        end
    endtask

    task automatic test_collision();
        auto_ack       = 1'b0;
        xfer_ack_async = 1'b0;
        err_clr        = 1'b1;
        s_valid        = 1'b1;
        s_data         = 8'hC3;
        sb.push_back(8'hC3);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) s_valid = 1'b0;
            if (k >= 8) begin
                tests++;
                if (err_timeout !== (k >= 9)) begin
                    fails++;
                    $display("FAIL collision k=%0d: err_timeout=%b expected %b", k, err_timeout, k >= 9);
                end
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        tests++;
        if ({xfer_req, busy} !== 2'b11) begin
            fails++;
            $display("FAIL rstmid_pre: req/busy=%b expected 11", {xfer_req, busy});
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({xfer_req, busy, done, err_timeout, xfer_data} !== 12'h000) begin
            fails++;
            $display("FAIL rstmid_async: req/busy/done/err=%b data=%h expected 0000 00",
                     {xfer_req, busy, done, err_timeout}, xfer_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++;
            if ({done, busy, xfer_req, s_ready} !== 4'b0001) begin
                fails++;
                $display("FAIL rstmid_after k=%0d: done/busy/req/rdy=%b expected 0001", k, {done, busy, xfer_req, s_ready});
            end
        end
    endtask

    task automatic test_stale_ack();
        auto_ack       = 1'b0;
        xfer_ack_async = 1'b1;
        step();
        step();
        s_valid = 1'b1;
        s_data  = 8'h77;
        for (int k = 1; k <= 4; k++) begin
            tests++;
            if ({busy, xfer_req, s_ready} !== 3'b000) begin
                fails++;
                $display("FAIL stale_hold k=%0d: busy/req/rdy=%b expected 000", k, {busy, xfer_req, s_ready});
            end
            step();
        end
        xfer_ack_async = 1'b0;
        step();
        tests++;
        if ({busy, s_ready} !== 2'b00) begin
            fails++;
            $display("FAIL stale_fall1: busy/rdy=%b expected 00", {busy, s_ready});
        end
        step();
        tests++;
        if ({busy, s_ready} !== 2'b01) begin
            fails++;
            $display("FAIL stale_fall2: busy/rdy=%b expected 01", {busy, s_ready});
        end
        sb.push_back(8'h77);
        auto_ack = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) s_valid = 1'b0;
            tests++;
            if (done !== (k == 7)) begin
                fails++;
                $display("FAIL stale_done k=%0d: done=%b expected %b", k, done, k == 7);
            end
        end
    endtask

    task automatic test_drain();
        repeat (3) step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d words never requested, expected 0", sb.size());
        end
        tests++;
        if (done_seen != 5) begin
            fails++;
            $display("FAIL done_total: %0d done pulses, expected 5", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_stale_ack();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
